// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, sync and blanking decodes,
// frame counter and audio band registers. Define FRAME_LATCH_EN to latch bands once per frame.
module video_timing_gen #(
  parameter int ACTIVE_H = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int ACTIVE_V = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int FPS      = 60
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic [31:0] low_in,
  input  logic [31:0] middle_in,
  input  logic [31:0] high_in,
  output logic [10:0] h_count,
  output logic [9:0]  v_count,
  output logic        hor_sync,
  output logic        vert_sync,
  output logic        active_draw,
  output logic        new_frame,
  output logic [5:0]  frame_count,
  output logic [31:0] low_out,
  output logic [31:0] middle_out,
  output logic [31:0] high_out
);

  // All decodes compare at 16 bits so parameter sums never truncate.
  localparam logic [15:0] H_ACT   = 16'(ACTIVE_H);
  localparam logic [15:0] HS_BEG  = 16'(ACTIVE_H + H_FP);
  localparam logic [15:0] HS_END  = 16'(ACTIVE_H + H_FP + H_SYNC);
  localparam logic [15:0] H_LAST  = 16'(ACTIVE_H + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] V_ACT   = 16'(ACTIVE_V);
  localparam logic [15:0] VS_BEG  = 16'(ACTIVE_V + V_FP);
  localparam logic [15:0] VS_END  = 16'(ACTIVE_V + V_FP + V_SYNC);
  localparam logic [15:0] V_LAST  = 16'(ACTIVE_V + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] F_LAST  = 16'(FPS - 1);

  logic [15:0] h_ext;
  logic [15:0] v_ext;
  logic [15:0] f_ext;

  assign h_ext = {5'd0, h_count};
  assign v_ext = {6'd0, v_count};
  assign f_ext = {10'd0, frame_count};

  assign hor_sync    = (h_ext >= HS_BEG) && (h_ext < HS_END);
  assign vert_sync   = (v_ext >= VS_BEG) && (v_ext < VS_END);
  assign active_draw = (h_ext < H_ACT) && (v_ext < V_ACT);
  assign new_frame   = (h_ext == H_ACT) && (v_ext == V_ACT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      h_count     <= '0;
      v_count     <= '0;
      frame_count <= '0;
    end else begin
      if (h_ext == H_LAST) begin
        h_count <= '0;
        v_count <= (v_ext == V_LAST) ? 10'd0 : v_count + 10'd1;
      end else begin
        h_count <= h_count + 11'd1;
      end
      if (new_frame)
        frame_count <= (f_ext == F_LAST) ? 6'd0 : frame_count + 6'd1;
    end
  end

`ifdef FRAME_LATCH_EN
  // Bands only change at the start of vertical blanking, so bars never tear.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      low_out    <= '0;
      middle_out <= '0;
      high_out   <= '0;
    end else if (new_frame) begin
      low_out    <= low_in;
      middle_out <= middle_in;
      high_out   <= high_in;
    end
  end
`else
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      low_out    <= '0;
      middle_out <= '0;
      high_out   <= '0;
    end else begin
      low_out    <= low_in;
      middle_out <= middle_in;
      high_out   <= high_in;
    end
  end
`endif

endmodule
